// File: rtl/mult_accum_stage.sv
// Accumulates a burst of up to N_TERMS unsigned products; reports sum, term count and sticky overflow.
// Latency: result valid the cycle after the terminating product is accepted; one bubble per burst.
// Backpressure: in_ready is low while a result waits for out_ready; MULT_ACCUM_SAT_EN selects saturation.
module mult_accum_stage #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 10,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [3:0]        out_count,
    output logic              out_ovf
);

    localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [3:0]         cnt;
    logic               ovf;

    logic               accept;
    logic               term;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_nxt;
    logic [3:0]         cnt_nxt;
    logic               ovf_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        accept    = in_valid && (state == ACC);
        sum       = {1'b0, acc} + (ACC_W+1)'(in_prod);
        cnt_nxt   = cnt + 4'd1;
        ovf_nxt   = ovf | sum[ACC_W];
`ifdef MULT_ACCUM_SAT_EN
        // Once saturated, stay pinned at full scale for the rest of the burst.
        acc_nxt   = (sum[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt   = sum[ACC_W-1:0];
`endif
        term      = in_last || (cnt == LAST_IDX);
        state_nxt = state;
        case (state)
            ACC:     if (accept && term) state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // Result registers are loaded with the final values on the terminating
    // accept, so they track acc/cnt/ovf in DONE and keep the last result in ACC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (term) begin
                            out_acc   <= acc_nxt;
                            out_count <= cnt_nxt;
                            out_ovf   <= ovf_nxt;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accum_stage.sv
// Directed bench for mult_accum_stage: default, narrow-overflow and single-term instances.
module tb_mult_accum_stage;

    logic       clk;
    logic       rst_n;
    logic       vld  [3];
    logic       rdy  [3];
    logic [7:0] prod [3];
    logic       last [3];
    logic       ovld [3];
    logic       ordy [3];
    logic [3:0] ocnt [3];
    logic       oovf [3];
    logic [9:0] oacc0;
    logic [7:0] oacc1;
    logic [9:0] oacc2;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult_accum_stage #(.PROD_W(8), .ACC_W(10), .N_TERMS(4)) u_def (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_prod(prod[0]), .in_last(last[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_acc(oacc0), .out_count(ocnt[0]), .out_ovf(oovf[0])
    );

    mult_accum_stage #(.PROD_W(8), .ACC_W(8), .N_TERMS(2)) u_ovf (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_prod(prod[1]), .in_last(last[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_acc(oacc1), .out_count(ocnt[1]), .out_ovf(oovf[1])
    );

    mult_accum_stage #(.PROD_W(8), .ACC_W(10), .N_TERMS(1)) u_one (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[2]), .in_ready(rdy[2]), .in_prod(prod[2]), .in_last(last[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_acc(oacc2), .out_count(ocnt[2]), .out_ovf(oovf[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_of(input int k);
        case (k)
            0:       return 32'(oacc0);
            1:       return 32'(oacc1);
            default: return 32'(oacc2);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one product on instance k and hold it until accepted (bounded).
    task automatic send(input int k, input logic [7:0] p, input logic l);
        int n;
        vld[k]  = 1'b1;
        prod[k] = p;
        last[k] = l;
        n = 0;
        while (!rdy[k] && n < 20) begin
            step();
            n++;
        end
        if (!rdy[k]) check("accept_timeout", 32'(rdy[k]), 32'd1);
        step();
        vld[k]  = 1'b0;
        last[k] = 1'b0;
    endtask

    // Check a pending result on instance k, then hand it off.
    task automatic take(input int k, input string tag, input int acc, input int cnt, input bit ovf);
        check({tag, "_valid"}, 32'(ovld[k]), 32'd1);
        check({tag, "_acc"},   acc_of(k),    32'(acc));
        check({tag, "_count"}, 32'(ocnt[k]), 32'(cnt));
        check({tag, "_ovf"},   32'(oovf[k]), 32'(ovf));
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        check({tag, "_back_to_acc"}, 32'(rdy[k]), 32'd1);
    endtask

    initial begin
        int ovf_exp;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; prod[k] = '0; last[k] = 1'b0; ordy[k] = 1'b0;
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check("rst_in_ready",  32'(rdy[0]),  32'd1);
        check("rst_out_valid", 32'(ovld[0]), 32'd0);
        check("rst_out_acc",   acc_of(0),    32'd0);
        check("rst_out_count", 32'(ocnt[0]), 32'd0);
        check("rst_out_ovf",   32'(oovf[0]), 32'd0);

        // Full burst of 4 x 225 with in_valid held high.
        vld[0]  = 1'b1;
        prod[0] = 8'd225;
        for (int i = 0; i < 4; i++) begin
            check("full_in_ready", 32'(rdy[0]), 32'd1);
            step();
        end
        vld[0] = 1'b0;
        check("full_in_ready_done", 32'(rdy[0]), 32'd0);
        take(0, "full", 900, 4, 1'b0);
        check("full_hold_in_acc", acc_of(0), 32'd900);

        // Early close, then a fresh burst must start from zero.
        send(0, 8'd42, 1'b0);
        send(0, 8'd15, 1'b1);
        take(0, "early", 57, 2, 1'b0);
        send(0, 8'd5, 1'b1);
        take(0, "fresh", 5, 1, 1'b0);

        // Backpressure: a 9 waits while the 4x1 result is pending.
        for (int i = 0; i < 4; i++) send(0, 8'd1, 1'b0);
        vld[0]  = 1'b1;
        prod[0] = 8'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_acc",      acc_of(0),    32'd4);
            check("bp_in_ready", 32'(rdy[0]),  32'd0);
            check("bp_valid",    32'(ovld[0]), 32'd1);
        end
        ordy[0] = 1'b1;
        step();
        ordy[0] = 1'b0;
        check("bp_in_ready_back", 32'(rdy[0]), 32'd1);
        step();
        vld[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 8'd1, 1'b0);
        take(0, "bp_next", 12, 4, 1'b0);

        // in_last on the final allowed term: one transition only.
        for (int i = 0; i < 3; i++) send(0, 8'd1, 1'b0);
        send(0, 8'd1, 1'b1);
        take(0, "last_at_max", 4, 4, 1'b0);
        step();
        check("last_at_max_no_extra", 32'(ovld[0]), 32'd0);

        // Zero products still count as terms.
        send(0, 8'd0, 1'b0);
        send(0, 8'd0, 1'b1);
        take(0, "zeros", 0, 2, 1'b0);

        // Reset mid-burst discards the partial sum.
        send(0, 8'd3, 1'b0);
        send(0, 8'd3, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_valid",    32'(ovld[0]), 32'd0);
        check("mrst_in_ready", 32'(rdy[0]),  32'd1);
        check("mrst_acc",      acc_of(0),    32'd0);
        check("mrst_count",    32'(ocnt[0]), 32'd0);
        for (int i = 0; i < 4; i++) send(0, 8'd1, 1'b0);
        take(0, "mrst_next", 4, 4, 1'b0);

        // Overflow on ACC_W=8, N_TERMS=2: 200 + 100 = 300.
`ifdef MULT_ACCUM_SAT_EN
        ovf_exp = 255;
`else
        ovf_exp = 44;
`endif
        send(1, 8'd200, 1'b0);
        send(1, 8'd100, 1'b0);
        take(1, "ovf", ovf_exp, 2, 1'b1);
        send(1, 8'd10, 1'b0);
        send(1, 8'd20, 1'b0);
        take(1, "ovf_cleared", 30, 2, 1'b0);

        // N_TERMS=1: every product is its own burst.
        send(2, 8'd7, 1'b0);
        take(2, "one_a", 7, 1, 1'b0);
        send(2, 8'd8, 1'b0);
        take(2, "one_b", 8, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
